id_ex_hazard_stage: RTL and testbench

ID/EX pipeline register with integrated load-use and ecall interlock for the 5-stage RV32I core. It sits between decode and execute, captures decoded fields each cycle, and drives the ID/EX rs1/rs2/rd and write-enable values that the data forwarding unit compares against EX/MEM and MEM/WB. It also owns the pipeline-drain halt sequencer that is entered when an `ecall` with x17 == 10 is decoded.

---
 rtl/id_ex_hazard_stage.sv | 168 ++++++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use / ecall interlock and the halt-ecall drain sequencer.
// Latency: ID to EX in 1 cycle; stall, pc_write and if_id_write respond combinationally in the same cycle.
// Backpressure: stall freezes the PC and IF/ID and bubbles ID/EX; ex_flush overrides stall; DRAIN/HALTED freeze the front end.
module id_ex_hazard_stage #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [7:0]  id_ctrl,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_pc,
    input  logic        id_is_ecall,
    input  logic        id_a7_is_10,
    input  logic        ex_flush,
    input  logic [4:0]  mem_rd,
    input  logic        mem_mem_read,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [7:0]  ex_ctrl,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc,
    output logic        ex_valid,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        stall,
    output logic        is_halted
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Fields cleared by a bubble; the forwarding unit only looks at these.
    typedef struct packed {
        logic       valid;
        logic [7:0] ctrl;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } hdr_t;

    typedef struct packed {
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
    } dat_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    hdr_t          hdr_q, hdr_d;
    dat_t          dat_q, dat_d;

    logic in_run;
    logic lu_hit;
    logic ec_hit;
    logic bubble;
    logic halt_accept;

    assign in_run = (state_q == RUN);

    assign lu_hit = hdr_q.valid && hdr_q.ctrl[1] && (hdr_q.rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == hdr_q.rd)) ||
                     (id_use_rs2 && (id_rs2 == hdr_q.rd)));

    // A load in EX/MEM only forwards its address, so x17 is not yet usable.
    assign ec_hit = id_is_ecall &&
                    ((hdr_q.valid && hdr_q.ctrl[0] && (hdr_q.rd == 5'd17)) ||
                     (mem_mem_read && (mem_rd == 5'd17)));

    assign stall       = id_valid && (lu_hit || ec_hit) && !ex_flush && in_run;
    assign pc_write    = !stall && in_run;
    assign if_id_write = !stall && in_run;
    assign bubble      = ex_flush || stall || !in_run;
    assign halt_accept = in_run && id_valid && id_is_ecall && id_a7_is_10 && !stall && !ex_flush;
    assign is_halted   = (state_q == HALTED);

    always_comb begin
        hdr_d       = hdr_q;
        dat_d       = dat_q;
        if (bubble) begin
            hdr_d = '0;
        end else begin
            hdr_d.valid    = id_valid;
            hdr_d.ctrl     = id_ctrl;
            hdr_d.rd       = id_rd;
            hdr_d.rs1      = id_rs1;
            hdr_d.rs2      = id_rs2;
            dat_d.rs1_data = id_rs1_data;
            dat_d.rs2_data = id_rs2_data;
            dat_d.imm      = id_imm;
            dat_d.pc       = id_pc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hdr_q <= '0;
            dat_q <= '0;
        end else begin
            hdr_q <= hdr_d;
            dat_q <= dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (halt_accept) begin
                    state_d = DRAIN;
                    cnt_d   = CW'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid    = hdr_q.valid;
    assign ex_ctrl     = hdr_q.ctrl;
    assign ex_rd       = hdr_q.rd;
    assign ex_rs1      = hdr_q.rs1;
    assign ex_rs2      = hdr_q.rs2;
    assign ex_rs1_data = dat_q.rs1_data;
    assign ex_rs2_data = dat_q.rs2_data;
    assign ex_imm      = dat_q.imm;
    assign ex_pc       = dat_q.pc;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Randomized and directed bench for id_ex_hazard_stage against a cycle-count reference model.
module tb_id_ex_hazard_stage;

    localparam int D = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [7:0]  id_ctrl;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic        id_is_ecall, id_a7_is_10, ex_flush;
    logic [4:0]  mem_rd;
    logic        mem_mem_read;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [7:0]  ex_ctrl;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
    logic        ex_valid, pc_write, if_id_write, stall, is_halted;

    always #5 clk = ~clk;

    id_ex_hazard_stage #(.DRAIN_CYCLES(D)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_ctrl(id_ctrl),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
        .id_is_ecall(id_is_ecall), .id_a7_is_10(id_a7_is_10), .ex_flush(ex_flush),
        .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_valid(ex_valid), .pc_write(pc_write), .if_id_write(if_id_write),
        .stall(stall), .is_halted(is_halted)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: ID/EX contents plus the edge index at which a halt-ecall was taken.
    logic        m_valid;
    logic [7:0]  m_ctrl;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [31:0] m_d1, m_d2, m_imm, m_pc;
    int          cyc = 0;
    int          acc_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit m_run();
        return acc_cyc < 0;
    endfunction

    function automatic bit m_halted();
        return (acc_cyc >= 0) && ((cyc - acc_cyc) >= D);
    endfunction

    function automatic bit m_stall();
        bit lu, ec;
        lu = m_valid && m_ctrl[1] && (m_rd != 5'd0) &&
             ((id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd));
        ec = id_is_ecall && ((m_valid && m_ctrl[0] && m_rd == 5'd17) ||
                             (mem_mem_read && mem_rd == 5'd17));
        return id_valid && (lu || ec) && !ex_flush && m_run();
    endfunction

    task automatic model_reset();
        {m_valid, m_ctrl, m_rd, m_rs1, m_rs2} = '0;
        {m_d1, m_d2, m_imm, m_pc} = '0;
        acc_cyc = -1;
    endtask

    task automatic model_edge();
        bit st, acc;
        cyc++;
        if (!reset_n) begin
            model_reset();
            return;
        end
        st  = m_stall();
        acc = m_run() && id_valid && id_is_ecall && id_a7_is_10 && !st && !ex_flush;
        if (ex_flush || st || !m_run()) begin
            {m_valid, m_ctrl, m_rd, m_rs1, m_rs2} = '0;
        end else begin
            m_valid = id_valid; m_ctrl = id_ctrl; m_rd = id_rd;
            m_rs1 = id_rs1; m_rs2 = id_rs2;
            m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm; m_pc = id_pc;
        end
        if (acc) acc_cyc = cyc;
    endtask

    task automatic compare_all();
        bit s, run;
        s   = m_stall();
        run = m_run();
        chk("ex_valid", ex_valid, m_valid);
        chk("ex_ctrl", ex_ctrl, m_ctrl);
        chk("ex_rd", ex_rd, m_rd);
        chk("ex_rs1", ex_rs1, m_rs1);
        chk("ex_rs2", ex_rs2, m_rs2);
        chk("ex_rs1_data", ex_rs1_data, m_d1);
        chk("ex_rs2_data", ex_rs2_data, m_d2);
        chk("ex_imm", ex_imm, m_imm);
        chk("ex_pc", ex_pc, m_pc);
        chk("stall", stall, s);
        chk("pc_write", pc_write, !s && run);
        chk("if_id_write", if_id_write, !s && run);
        chk("is_halted", is_halted, m_halted());
    endtask

    // Called with inputs settled mid-cycle; returns 1 time unit after the next rising edge.
    task automatic step();
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_ctrl = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0;
        id_is_ecall = 0; id_a7_is_10 = 0; ex_flush = 0;
        mem_rd = 0; mem_mem_read = 0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2, input logic [7:0] ctrl);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_ctrl = ctrl;
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom; id_pc = $urandom;
        id_is_ecall = 0; id_a7_is_10 = 0;
    endtask

    task automatic set_ecall(input logic a7);
        set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'h00);
        id_is_ecall = 1;
        id_a7_is_10 = a7;
    endtask

    // Asserts reset mid-cycle, checks the asynchronous response, releases after one edge.
    task automatic do_reset();
        idle();
        reset_n = 0;
        #1;
        model_reset();
        chk("rst_is_halted", is_halted, 0);
        chk("rst_stall", stall, 0);
        chk("rst_pc_write", pc_write, 1);
        chk("rst_if_id_write", if_id_write, 1);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_ctrl", ex_ctrl, 0);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
        reset_n = 1;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd5;
            2:       return 5'd17;
            default: return 5'($urandom);
        endcase
    endfunction

    task automatic rand_inputs();
        set_id(pick_reg(), pick_reg(), pick_reg(), 1'($urandom), 1'($urandom), 8'($urandom));
        id_valid     = ($urandom_range(0, 5) != 0);
        id_is_ecall  = ($urandom_range(0, 3) == 0);
        id_a7_is_10  = ($urandom_range(0, 7) == 0);
        ex_flush     = ($urandom_range(0, 7) == 0);
        mem_rd       = pick_reg();
        mem_mem_read = 1'($urandom);
    endtask

    initial begin
        reset_n = 0;
        idle();
        model_reset();
        #2;
        chk("init_is_halted", is_halted, 0);
        chk("init_pc_write", pc_write, 1);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
        reset_n = 1;

        // Load-use on rs1: lw x5 then add x6,x5,x1.
        set_id(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 8'h0B); #1; step();
        set_id(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 8'h01); #1;
        chk("lu_stall", stall, 1);
        chk("lu_pc_write", pc_write, 0);
        step();
        chk("lu_bubble_ctrl", ex_ctrl, 0);
        chk("lu_bubble_rd", ex_rd, 0);
        mem_mem_read = 1; mem_rd = 5'd5; #1;
        chk("lu_stall_cleared", stall, 0);
        step();
        chk("lu_add_rd", ex_rd, 6);
        chk("lu_add_valid", ex_valid, 1);
        mem_mem_read = 0; mem_rd = 0;

        // lw x0 followed by a use of x0.
        set_id(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 8'h0B); #1; step();
        set_id(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 8'h01); #1;
        chk("x0_no_stall", stall, 0);
        step();

        // lw x5 followed by jal (no sources used).
        set_id(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 8'h0B); #1; step();
        set_id(5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 8'h41); #1;
        chk("jal_no_stall", stall, 0);
        step();

        // Flush beats stall.
        set_id(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 8'h0B); #1; step();
        set_id(5'd5, 5'd2, 5'd6, 1'b1, 1'b1, 8'h01); ex_flush = 1; #1;
        chk("flush_stall", stall, 0);
        chk("flush_pc_write", pc_write, 1);
        step();
        chk("flush_bubble", ex_valid, 0);
        ex_flush = 0;

        // Ecall behind lw x17: two stall cycles.
        set_id(5'd1, 5'd0, 5'd17, 1'b1, 1'b0, 8'h0B); #1; step();
        set_ecall(1'b0); #1;
        chk("ec_stall1", stall, 1);
        step();
        mem_mem_read = 1; mem_rd = 5'd17; #1;
        chk("ec_stall2", stall, 1);
        step();
        mem_mem_read = 0; mem_rd = 0; #1;
        chk("ec_stall_done", stall, 0);
        step();
        chk("ec_entered", ex_valid, 1);

        // Halt sequence.
        idle(); #1; step();
        set_ecall(1'b1); #1;
        chk("halt_accept_stall", stall, 0);
        step();
        chk("halt_ecall_in_ex", ex_valid, 1);
        set_id(5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 8'h01); #1;
        chk("drain_pc_write", pc_write, 0);
        step();
        chk("drain_bubble", ex_valid, 0);
        chk("drain_not_halted1", is_halted, 0);
        step();
        chk("drain_not_halted2", is_halted, 0);
        step();
        chk("halted", is_halted, 1);
        step();
        chk("halted_held", is_halted, 1);

        // Reset in the middle of a drain.
        do_reset();
        set_ecall(1'b1); #1; step();
        idle(); #1; step();
        step();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle(); #1;
            chk("post_rst_not_halted", is_halted, 0);
            step();
        end

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            rand_inputs();
            #1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
